tick_bcd_counter: RTL and testbench
===================================

// Module: tick_bcd_counter
// PURPOSE
//   Multi-digit decimal (BCD) counter advanced by the single-cycle update tick from the
//   upstream tick divider. Start/stop/clear control FSM; BCD digits feed the display driver.
//   Sits between the tick generator and the 7-segment scan stage in the counter design.
// PARAMETERS
//   DIGITS   4   number of decade digits (1..8); output width 4*DIGITS
// PORTS
//   clk       in   1         system clock
//   rst_n     in   1         asynchronous reset, active-low
//   tick      in   1         count enable pulse (1 clk wide) from tick divider
//   start     in   1         start/resume pulse (debounced upstream)
//   stop      in   1         pause pulse
//   clear     in   1         zero counter and return to IDLE
//   dir       in   1         1 = count down, 0 = up (only when COUNT_DOWN_EN defined)
//   bcd       out  4*DIGITS  digit i at bcd[4i+3:4i], digit 0 = least significant
//   running   out  1         high while FSM in RUN
//   wrap      out  1         1-cycle pulse on full-range wrap
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, bcd=0, running=0, wrap=0. Reset mid-count
//     discards the value immediately; no tick is counted on the release edge.
//   - FSM states IDLE, RUN, PAUSE, all transitions on posedge clk:
//     IDLE -start-> RUN; RUN -stop-> PAUSE; PAUSE -start-> RUN; any -clear-> IDLE.
//   - Priority: clear > (start,stop). start and stop high together: no state change.
//   - Counting: counter increments on a clk edge iff state==RUN and tick==1 at that edge
//     (current state, not next). Thus tick with stop in RUN is counted; tick with start in
//     IDLE/PAUSE is not. clear with tick: clear wins, bcd=0.
//   - Latency: bcd reflects the tick one cycle after tick sampled high (registered output).
//   - running is registered, equals (state==RUN).
//   - Digit arithmetic: each digit 0..9; digit i increments when all lower digits are 9
//     and a count occurs; 9 -> 0 with carry. Digit values 10..15 never appear.
//   - Full wrap: 99..9 -> 00..0 on a count; wrap pulses high on that same edge for exactly
//     one cycle; counting continues in RUN. wrap=0 at all other times.
//   - bcd holds in IDLE (always 0) and PAUSE (frozen value).
// CONFIGURATION
//   COUNT_DOWN_EN defined: dir port present; dir=1 decrements, digit 0 -> 9 with borrow,
//     00..0 -> 99..9 wraps and pulses wrap. dir sampled on the same edge as tick.
//   COUNT_DOWN_EN undefined: dir port absent; up-count only, logic identical otherwise.
// STRUCTURE
//   Shared package: FSM state enum (IDLE/RUN/PAUSE), BCD_MAX = 4'd9, BCD_W = 4.
//   Sub-module bcd_digit: one decade cell (en, up, q[3:0], carry/borrow out);
//   instantiated DIGITS times via generate, carry chained combinationally; top holds FSM.
// TESTING
//   1. Reset, start, 12 ticks (DIGITS=4) -> bcd=16'h0012, running=1, wrap never high.
//   2. Preload via 9999 ticks then 1 tick -> bcd=16'h0000, wrap=1 for exactly one cycle.
//   3. stop with tick same cycle at bcd=0x0041 -> bcd=0x0042, running=0; further ticks hold.
//   4. clear with tick and start same cycle in RUN at 0x0123 -> bcd=0, state IDLE, running=0.
//   5. start+stop same cycle in PAUSE -> stays PAUSE; rst_n low mid-RUN -> all outputs 0 async.
//   6. COUNT_DOWN_EN: dir=1 from 0x0000, one tick -> bcd=0x9999, wrap=1; 0x0100 -1 -> 0x0099.

Source files
------------

// File: rtl/tick_bcd_counter_pkg.sv
// Shared definitions for the tick-driven BCD counter.
//   state_e      : control FSM states (idle / run / pause)
//   BCD_W        : bits per decade digit
//   BCD_MAX      : largest legal digit value
//   bcd_step     : next value of one digit when it counts up or down
//   bcd_terminal : digit is at the value that produces a carry (up) or borrow (down)
package tick_bcd_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] q, input logic up);
    logic [BCD_W-1:0] r;
    if (up) begin
      r = (q >= BCD_MAX) ? '0 : q + 4'd1;
    end else begin
      // Out-of-range values cannot occur; map them to 9 so a digit can never stick above 9.
      r = (q == '0 || q > BCD_MAX) ? BCD_MAX : q - 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_terminal(input logic [BCD_W-1:0] q, input logic up);
    return up ? (q == BCD_MAX) : (q == '0);
  endfunction

endpackage

// File: rtl/tick_bcd_counter_if.sv
// Control/status bundle between the tick/control source and the BCD counter.
//   master : drives tick, start, stop, clear (and dir); observes bcd, running, wrap
//   slave  : the counter side
// dir exists only when COUNT_DOWN_EN is defined.
interface tick_bcd_counter_if
  import tick_bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  logic                    tick;
  logic                    start;
  logic                    stop;
  logic                    clear;
`ifdef COUNT_DOWN_EN
  logic                    dir;
`endif
  logic [BCD_W*DIGITS-1:0] bcd;
  logic                    running;
  logic                    wrap;

`ifdef COUNT_DOWN_EN
  modport master (
    output tick, start, stop, clear, dir,
    input  bcd, running, wrap
  );
  modport slave (
    input  tick, start, stop, clear, dir,
    output bcd, running, wrap
  );
`else
  modport master (
    output tick, start, stop, clear,
    input  bcd, running, wrap
  );
  modport slave (
    input  tick, start, stop, clear,
    output bcd, running, wrap
  );
`endif

endinterface

// File: rtl/tick_bcd_counter_bcd_digit.sv
// One decade cell of the BCD counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear to 0 (wins over i_en)
//   i_en       : count this cycle (all lower digits terminal and a count occurs)
//   i_up       : 1 = increment, 0 = decrement
//   o_q        : current digit value 0..9
//   o_co       : carry (up) / borrow (down) into the next digit, combinational
module bcd_digit
  import tick_bcd_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_up,
  output logic [BCD_W-1:0] o_q,
  output logic             o_co
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= bcd_step(r_q, i_up);
    end
  end

  assign o_q  = r_q;
  assign o_co = i_en & bcd_terminal(r_q, i_up);

endmodule

// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD counter advanced by a one-cycle tick, with start/stop/clear control FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tick_bcd_counter_if.slave
//                in : tick, start, stop, clear (dir when COUNT_DOWN_EN is defined)
//                out: bcd (digit i at [4i+3:4i]), running (state == RUN), wrap (full-range pulse)
// DIGITS (1..8) must match the DIGITS of the connected interface.
// Optional feature macro: COUNT_DOWN_EN (adds dir; dir=1 counts down).
module tick_bcd_counter
  import tick_bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input logic             clk,
  input logic             rst_n,
  tick_bcd_counter_if.slave bus
);

  state_e                  r_state;
  state_e                  w_state_d;
  logic                    r_running;
  logic                    w_running_d;
  logic                    r_wrap;
  logic                    w_count;
  logic                    w_up;
  logic                    w_start_only;
  logic                    w_stop_only;
  logic [DIGITS:0]         w_en;
  logic [BCD_W*DIGITS-1:0] w_bcd;

  // start and stop together cancel each other out.
  assign w_start_only = bus.start & ~bus.stop;
  assign w_stop_only  = bus.stop & ~bus.start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_running <= w_running_d;
    end
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start_only) w_state_d = StRun;
      StRun:   if (w_stop_only)  w_state_d = StPause;
      StPause: if (w_start_only) w_state_d = StRun;
      default: w_state_d = StIdle;
    endcase
    if (bus.clear) begin
      w_state_d = StIdle;
    end
  end

  // Output logic. Counting is qualified by the current state, so a tick arriving with stop
  // is still counted while a tick arriving with start is not.
  always_comb begin
    w_running_d = (w_state_d == StRun);
    w_count     = (r_state == StRun) & bus.tick & ~bus.clear;
  end

`ifdef COUNT_DOWN_EN
  assign w_up = ~bus.dir;
`else
  assign w_up = 1'b1;
`endif

  // Ripple enable: digit g+1 counts only when digit g carries/borrows.
  assign w_en[0] = w_count;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (bus.clear),
      .i_en  (w_en[g]),
      .i_up  (w_up),
      .o_q   (w_bcd[BCD_W*g +: BCD_W]),
      .o_co  (w_en[g+1])
    );
  end

  // Carry out of the top digit is exactly the full-range wrap event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_en[DIGITS];
    end
  end

  assign bus.bcd     = w_bcd;
  assign bus.running = r_running;
  assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_tick_bcd_counter.sv
module tb_tick_bcd_counter;

  localparam int unsigned DIGITS = 4;
  localparam int          MODV   = 10000;
  localparam int          MI = 0, MR = 1, MP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tick_bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  tick_bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic                running;
    logic                wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_val = 0;
  int   m_st = MI;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's view of the result of the next edge.
  task automatic step(input bit tk, input bit st, input bit sp, input bit cl, input bit dn);
    bit   up;
    bit   cnt;
    bit   wr;
    exp_t e;
    @(negedge clk);
    bus.tick  = tk;
    bus.start = st;
    bus.stop  = sp;
    bus.clear = cl;
`ifdef COUNT_DOWN_EN
    bus.dir   = dn;
    up = !dn;
`else
    up = 1'b1;
`endif
    cnt = (m_st == MR) && tk && !cl;
    wr  = cnt && (up ? (m_val == MODV - 1) : (m_val == 0));
    if (cl) m_val = 0;
    else if (cnt) m_val = up ? (m_val + 1) % MODV : (m_val + MODV - 1) % MODV;
    if (cl) m_st = MI;
    else if (st && !sp && m_st != MR) m_st = MR;
    else if (sp && !st && m_st == MR) m_st = MP;
    e.bcd     = to_bcd(m_val);
    e.running = (m_st == MR);
    e.wrap    = wr;
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n, input bit dn);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, dn);
  endtask

  // Direct spot check of the edge that follows the last step.
  task automatic expect_now(input string name, input logic [15:0] b, input bit run);
    @(posedge clk);
    #2;
    cmp({name, ".bcd"}, 32'(bus.bcd), 32'(b));
    cmp({name, ".running"}, 32'(bus.running), 32'(run));
  endtask

  // Monitor: every edge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("sb.bcd", 32'(bus.bcd), 32'(e.bcd));
        cmp("sb.running", 32'(bus.running), 32'(e.running));
        cmp("sb.wrap", 32'(bus.wrap), 32'(e.wrap));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.clear = 0;
`ifdef COUNT_DOWN_EN
    bus.dir = 0;
`endif
    #12;
    cmp("reset.bcd", 32'(bus.bcd), 32'h0);
    cmp("reset.running", 32'(bus.running), 32'h0);
    cmp("reset.wrap", 32'(bus.wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: start then 12 ticks.
    step(0, 1, 0, 0, 0);
    ticks(12, 0);
    expect_now("t1", 16'h0012, 1'b1);

    // 2: wrap from 9999.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(9999, 0);
    expect_now("t2_9999", 16'h9999, 1'b1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // 3: stop with tick at 0041.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(41, 0);
    step(1, 0, 1, 0, 0);
    expect_now("t3_stop", 16'h0042, 1'b0);
    ticks(3, 0);
    expect_now("t3_hold", 16'h0042, 1'b0);
    step(1, 1, 0, 0, 0);

    // 4: clear + tick + start in RUN at 0123.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(123, 0);
    step(1, 1, 0, 1, 0);
    expect_now("t4_clear", 16'h0000, 1'b0);

    // 5: start+stop in PAUSE, then async reset mid-RUN.
    step(0, 1, 0, 0, 0);
    ticks(5, 0);
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    expect_now("t5_pause", 16'h0005, 1'b0);
    step(0, 1, 0, 0, 0);
    ticks(7, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("t5_arst.bcd", 32'(bus.bcd), 32'h0);
    cmp("t5_arst.running", 32'(bus.running), 32'h0);
    cmp("t5_arst.wrap", 32'(bus.wrap), 32'h0);
    m_val = 0;
    m_st  = MI;
    bus.tick = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0);

`ifdef COUNT_DOWN_EN
    // 6: count down.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    expect_now("t6_under", 16'h9999, 1'b1);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(100, 0);
    step(1, 0, 0, 0, 1);
    expect_now("t6_borrow", 16'h0099, 1'b1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 39) == 0,
           bit'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    cmp("sb.drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
